// File: rtl/axi_simple_master_if.sv
// -----------------------------------------------------------------------------
// axi_channel
// Full AXI4 channel bundle (AW, W, B, AR, R) shared between one master and one
// slave. clk/rstn travel with the bundle for slaves that want them.
// Modports:
//   master : drives AW/W/AR payloads and valids, B/R readies
//   slave  : the mirror image
// -----------------------------------------------------------------------------
interface axi_channel #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 1
) (
    input logic clk,
    input logic rstn
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [ID_WIDTH-1:0]       aw_id;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_cache;
    logic                      aw_lock;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [USER_WIDTH-1:0]     aw_user;

    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    logic                      w_last;

    logic                      b_valid;
    logic                      b_ready;
    logic [1:0]                b_resp;
    logic [ID_WIDTH-1:0]       b_id;

    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [ID_WIDTH-1:0]       ar_id;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_cache;
    logic                      ar_lock;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [USER_WIDTH-1:0]     ar_user;

    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;
    logic [ID_WIDTH-1:0]       r_id;
    logic                      r_last;

    modport master (
        input  clk, rstn,
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_prot,
               aw_cache, aw_lock, aw_qos, aw_region, aw_user,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_resp, b_id,
        output b_ready,
        output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_prot,
               ar_cache, ar_lock, ar_qos, ar_region, ar_user,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_id, r_last,
        output r_ready
    );

    modport slave (
        input  clk, rstn,
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_prot,
               aw_cache, aw_lock, aw_qos, aw_region, aw_user,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp, b_id,
        input  b_ready,
        input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_prot,
               ar_cache, ar_lock, ar_qos, ar_region, ar_user,
        output ar_ready,
        output r_valid, r_data, r_resp, r_id, r_last,
        input  r_ready
    );
endinterface

// File: rtl/axi_simple_master.sv
// -----------------------------------------------------------------------------
// axi_simple_master
// Single-outstanding AXI master: one command becomes one INCR burst. Writes
// send seed+k on beat k; reads XOR every beat into a checksum. A one-cycle
// done pulse reports the final response and any protocol error.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_write           1 = write burst, 0 = read burst
//   cmd_addr/len/id     burst address, AXI len, AXI id
//   cmd_data            write seed
//   done_valid          one-cycle completion pulse
//   done_resp/err/data  final response, protocol error, read checksum
//   slave               AXI master port
//
// state | meaning
// IDLE  | waiting for a command
// AW    | write address offered
// W     | write beats streaming
// B     | waiting for write response
// AR    | read address offered
// R     | read beats streaming
// DONE  | done pulse cycle
// -----------------------------------------------------------------------------
module axi_simple_master #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  done_valid,
    output logic [1:0]            done_resp,
    output logic                  done_err,
    output logic [DATA_WIDTH-1:0] done_data,
    axi_channel.master            slave
);
    localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH / 8));

    if ($bits(slave.w_data) != DATA_WIDTH) begin : g_bad_data_width
        $fatal(1, "axi_simple_master: DATA_WIDTH does not match interface");
    end
    if ($bits(slave.aw_addr) != ADDR_WIDTH) begin : g_bad_addr_width
        $fatal(1, "axi_simple_master: ADDR_WIDTH does not match interface");
    end
    if ($bits(slave.aw_id) != ID_WIDTH) begin : g_bad_id_width
        $fatal(1, "axi_simple_master: ID_WIDTH does not match interface");
    end

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_seed;
    logic [8:0]            r_beat;
    logic [DATA_WIDTH-1:0] r_csum;
    logic [1:0]            r_done_resp;
    logic                  r_err;
    logic                  r_done_valid;
    logic                  r_aw_valid;
    logic                  r_w_valid;
    logic                  r_b_ready;
    logic                  r_ar_valid;
    logic                  r_r_ready;

    logic [8:0]            w_len_ext;
    logic [8:0]            w_beat_inc;

    assign w_len_ext  = {1'b0, r_len};
    // Counter saturates so a slave that never sends r_last cannot wrap it.
    assign w_beat_inc = (r_beat == 9'd511) ? r_beat : r_beat + 9'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_len        <= '0;
            r_id         <= '0;
            r_seed       <= '0;
            r_beat       <= '0;
            r_csum       <= '0;
            r_done_resp  <= 2'b00;
            r_err        <= 1'b0;
            r_done_valid <= 1'b0;
            r_aw_valid   <= 1'b0;
            r_w_valid    <= 1'b0;
            r_b_ready    <= 1'b0;
            r_ar_valid   <= 1'b0;
            r_r_ready    <= 1'b0;
        end else begin
            r_done_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= cmd_addr;
                        r_len       <= cmd_len;
                        r_id        <= cmd_id;
                        r_seed      <= cmd_data;
                        r_beat      <= '0;
                        r_csum      <= '0;
                        r_done_resp <= 2'b00;
                        r_err       <= 1'b0;
                        if (cmd_write) begin
                            r_aw_valid <= 1'b1;
                            r_state    <= S_AW;
                        end else begin
                            r_ar_valid <= 1'b1;
                            r_state    <= S_AR;
                        end
                    end
                end
                S_AW: begin
                    if (slave.aw_ready) begin
                        r_aw_valid <= 1'b0;
                        r_w_valid  <= 1'b1;
                        r_state    <= S_W;
                    end
                end
                S_W: begin
                    if (slave.w_ready) begin
                        r_beat <= w_beat_inc;
                        if (r_beat == w_len_ext) begin
                            r_w_valid <= 1'b0;
                            r_b_ready <= 1'b1;
                            r_state   <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (slave.b_valid) begin
                        r_done_resp  <= slave.b_resp;
                        if (slave.b_id != r_id) r_err <= 1'b1;
                        r_b_ready    <= 1'b0;
                        r_done_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_AR: begin
                    if (slave.ar_ready) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= S_R;
                    end
                end
                S_R: begin
                    if (slave.r_valid) begin
                        r_csum <= r_csum ^ slave.r_data;
                        r_beat <= w_beat_inc;
                        // Only the first non-OKAY response sticks.
                        if (r_done_resp == 2'b00 && slave.r_resp != 2'b00)
                            r_done_resp <= slave.r_resp;
                        // Wrong id, early r_last, or no r_last at/after the final beat.
                        if ((slave.r_id != r_id) ||
                            (slave.r_last && r_beat != w_len_ext) ||
                            (!slave.r_last && r_beat >= w_len_ext))
                            r_err <= 1'b1;
                        if (slave.r_last) begin
                            r_r_ready    <= 1'b0;
                            r_done_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign done_valid = r_done_valid;
    assign done_resp  = r_done_resp;
    assign done_err   = r_err;
    assign done_data  = r_csum;

    assign slave.aw_valid  = r_aw_valid;
    assign slave.aw_addr   = r_addr;
    assign slave.aw_id     = r_id;
    assign slave.aw_len    = r_len;
    assign slave.aw_size   = SIZE;
    assign slave.aw_burst  = 2'b01;
    assign slave.aw_prot   = '0;
    assign slave.aw_cache  = '0;
    assign slave.aw_lock   = 1'b0;
    assign slave.aw_qos    = '0;
    assign slave.aw_region = '0;
    assign slave.aw_user   = '0;

    assign slave.w_valid   = r_w_valid;
    assign slave.w_data    = r_seed + DATA_WIDTH'(r_beat);
    assign slave.w_strb    = '1;
    assign slave.w_last    = (r_beat == w_len_ext);

    assign slave.b_ready   = r_b_ready;

    assign slave.ar_valid  = r_ar_valid;
    assign slave.ar_addr   = r_addr;
    assign slave.ar_id     = r_id;
    assign slave.ar_len    = r_len;
    assign slave.ar_size   = SIZE;
    assign slave.ar_burst  = 2'b01;
    assign slave.ar_prot   = '0;
    assign slave.ar_cache  = '0;
    assign slave.ar_lock   = 1'b0;
    assign slave.ar_qos    = '0;
    assign slave.ar_region = '0;
    assign slave.ar_user   = '0;

    assign slave.r_ready   = r_r_ready;
endmodule

// File: tb/tb_axi_simple_master.sv
module tb_axi_simple_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [47:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [7:0]  cmd_id;
    logic [63:0] cmd_data;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic        done_err;
    logic [63:0] done_data;

    always #5 clk = ~clk;
    assign rstn = ~rst;

    axi_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(64), .ID_WIDTH(8), .USER_WIDTH(1))
        u_axi (.clk(clk), .rstn(rstn));

    axi_simple_master #(.ADDR_WIDTH(48), .DATA_WIDTH(64), .ID_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_data(cmd_data),
        .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
        .done_data(done_data), .slave(u_axi)
    );

    int checks = 0;
    int errors = 0;

    // observations collected by the run_* drivers
    logic [63:0] obs_w[$];
    bit          obs_last[$];
    logic [1:0]  o_resp;
    logic        o_err;
    logic [63:0] o_data;
    int          o_done_cnt, o_done_cyc, o_last_cyc, o_beats, o_aw_cnt;
    bit          o_unstable, o_timeout, o_ready_after;
    logic [47:0] o_aw_addr;
    logic [7:0]  o_aw_len, o_aw_id;
    logic [2:0]  o_aw_size;
    logic [1:0]  o_aw_burst;

    // read stimulus
    logic [63:0] rd_data[$];
    logic [1:0]  rd_resp[$];
    bit          rd_last[$];

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0; cmd_data = '0;
        u_axi.aw_ready = 0; u_axi.w_ready = 0;
        u_axi.b_valid = 0; u_axi.b_resp = 0; u_axi.b_id = 0;
        u_axi.ar_ready = 0;
        u_axi.r_valid = 0; u_axi.r_data = '0; u_axi.r_resp = 0; u_axi.r_id = 0; u_axi.r_last = 0;
    endtask

    task automatic capture_done(input int cyc);
        if (o_done_cnt == 0) o_done_cyc = cyc;
        o_done_cnt++;
        o_resp = done_resp; o_err = done_err; o_data = done_data;
    endtask

    task automatic run_write(input logic [7:0] len, input logic [63:0] seed, input logic [7:0] id,
                             input logic [1:0] bresp, input logic [7:0] bid,
                             input int aw_delay, input bit w_toggle);
        bit          prev_stall, prev_aw_wait, tog;
        logic [63:0] prev_wd;
        logic [47:0] prev_aa;
        obs_w.delete(); obs_last.delete();
        o_done_cnt = 0; o_done_cyc = -1; o_unstable = 0; o_timeout = 1;
        o_aw_cnt = 0; o_ready_after = 0;
        prev_stall = 0; prev_aw_wait = 0; tog = 0; prev_wd = '0; prev_aa = '0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 48'h1234_5678_9A00;
        cmd_len = len; cmd_id = id; cmd_data = seed;
        u_axi.aw_ready = 0; u_axi.w_ready = 0;
        u_axi.b_valid = 1; u_axi.b_resp = bresp; u_axi.b_id = bid;
        for (int cyc = 1; cyc < 200; cyc++) begin
            @(negedge clk);
            cmd_valid = 0;
            if (prev_aw_wait && (!u_axi.aw_valid || u_axi.aw_addr !== prev_aa)) o_unstable = 1;
            if (u_axi.aw_valid) begin
                u_axi.aw_ready = (o_aw_cnt >= aw_delay);
                if (u_axi.aw_ready) begin
                    o_aw_addr = u_axi.aw_addr; o_aw_len = u_axi.aw_len; o_aw_id = u_axi.aw_id;
                    o_aw_size = u_axi.aw_size; o_aw_burst = u_axi.aw_burst;
                end
                prev_aw_wait = !u_axi.aw_ready;
                prev_aa = u_axi.aw_addr;
                o_aw_cnt++;
            end else begin
                u_axi.aw_ready = 0; prev_aw_wait = 0;
            end
            if (prev_stall && (!u_axi.w_valid || u_axi.w_data !== prev_wd)) o_unstable = 1;
            if (u_axi.w_valid) begin
                if (u_axi.aw_valid) o_unstable = 1;
                tog = !tog;
                u_axi.w_ready = w_toggle ? !tog : 1'b1;
                if (u_axi.w_ready) begin
                    obs_w.push_back(u_axi.w_data);
                    obs_last.push_back(u_axi.w_last);
                end
                prev_stall = !u_axi.w_ready;
                prev_wd = u_axi.w_data;
            end else begin
                u_axi.w_ready = 0; prev_stall = 0;
            end
            if (done_valid) capture_done(cyc);
            else if (o_done_cnt > 0) begin
                o_ready_after = cmd_ready; o_timeout = 0;
                break;
            end
        end
        idle_inputs();
    endtask

    task automatic run_read(input logic [7:0] len, input logic [7:0] id, input logic [7:0] rid);
        int k;
        k = 0;
        o_done_cnt = 0; o_done_cyc = -1; o_last_cyc = -1; o_timeout = 1; o_ready_after = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 48'h0000_0000_1000;
        cmd_len = len; cmd_id = id; cmd_data = '0;
        u_axi.ar_ready = 1; u_axi.r_valid = 0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            @(negedge clk);
            cmd_valid = 0;
            if (u_axi.r_ready && k < rd_data.size()) begin
                u_axi.r_valid = 1; u_axi.r_data = rd_data[k]; u_axi.r_resp = rd_resp[k];
                u_axi.r_last = rd_last[k]; u_axi.r_id = rid;
                if (rd_last[k] && o_last_cyc < 0) o_last_cyc = cyc;
                k++;
            end else begin
                u_axi.r_valid = 0; u_axi.r_last = 0;
            end
            if (done_valid) capture_done(cyc);
            else if (o_done_cnt > 0) begin
                o_ready_after = cmd_ready; o_timeout = 0;
                break;
            end
        end
        o_beats = k;
        idle_inputs();
    endtask

    task automatic set_read(input logic [63:0] d0, input logic [1:0] r0, input bit l0);
        rd_data.push_back(d0); rd_resp.push_back(r0); rd_last.push_back(l0);
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++;
        if ({u_axi.aw_valid, u_axi.w_valid, u_axi.ar_valid, u_axi.b_ready, u_axi.r_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_valids: got %b expected 00000",
                {u_axi.aw_valid, u_axi.w_valid, u_axi.ar_valid, u_axi.b_ready, u_axi.r_ready});
        end
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid: got %b expected 0", done_valid); end
        checks++; if (done_resp !== 2'b00) begin errors++; $display("FAIL reset_done_resp: got %b expected 00", done_resp); end
        checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b expected 0", done_err); end
        checks++; if (done_data !== 64'h0) begin errors++; $display("FAIL reset_done_data: got %h expected 0", done_data); end
        rst = 0;
    endtask

    task automatic test_write_burst();
        run_write(8'd3, 64'h10, 8'd5, 2'b00, 8'd5, 0, 0);
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL wr_timeout: got %b expected 0", o_timeout); end
        checks++; if (obs_w.size() != 4) begin errors++; $display("FAIL wr_beats: got %0d expected 4", obs_w.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_w[i] !== 64'h10 + 64'(i) || obs_last[i] !== (i == 3)) begin
                errors++; $display("FAIL wr_beat[%0d]: got data %h last %b expected data %h last %b",
                    i, obs_w[i], obs_last[i], 64'h10 + 64'(i), (i == 3));
            end
        end
        checks++;
        if (o_aw_addr !== 48'h1234_5678_9A00 || o_aw_len !== 8'd3 || o_aw_id !== 8'd5 ||
            o_aw_size !== 3'd3 || o_aw_burst !== 2'b01) begin
            errors++; $display("FAIL wr_aw_fields: got addr %h len %0d id %0d size %0d burst %0d expected 123456789a00 3 5 3 1",
                o_aw_addr, o_aw_len, o_aw_id, o_aw_size, o_aw_burst);
        end
        checks++;
        if (o_resp !== 2'b00 || o_err !== 1'b0 || o_data !== 64'h0) begin
            errors++; $display("FAIL wr_done: got resp %b err %b data %h expected 00 0 0", o_resp, o_err, o_data);
        end
        checks++; if (o_done_cyc != 7) begin errors++; $display("FAIL wr_done_cycle: got %0d expected 7", o_done_cyc); end
        checks++; if (o_unstable !== 1'b0) begin errors++; $display("FAIL wr_handshake_stable: got %b expected 0", o_unstable); end
    endtask

    task automatic test_min_write();
        run_write(8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1, 2'b00, 8'd1, 0, 0);
        checks++; if (o_done_cyc != 4) begin errors++; $display("FAIL min_wr_latency: got %0d expected 4", o_done_cyc); end
        checks++;
        if (obs_w.size() != 1 || obs_w[0] !== 64'hFFFF_FFFF_FFFF_FFFF || obs_last[0] !== 1'b1) begin
            errors++; $display("FAIL min_wr_beat: got %0d beats first %h expected 1 beat ffffffffffffffff last", obs_w.size(), obs_w[0]);
        end
        checks++; if (o_ready_after !== 1'b1) begin errors++; $display("FAIL min_wr_cmd_ready: got %b expected 1", o_ready_after); end
    endtask

    task automatic test_read_burst();
        rd_data.delete(); rd_resp.delete(); rd_last.delete();
        set_read(64'hA5, 2'b00, 0);
        set_read(64'h0F, 2'b00, 1);
        run_read(8'd1, 8'd9, 8'd9);
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL rd_timeout: got %b expected 0", o_timeout); end
        checks++;
        if (o_data !== 64'hAA || o_resp !== 2'b00 || o_err !== 1'b0) begin
            errors++; $display("FAIL rd_done: got data %h resp %b err %b expected aa 00 0", o_data, o_resp, o_err);
        end
        checks++; if (o_done_cnt != 1) begin errors++; $display("FAIL rd_pulse_width: got %0d expected 1", o_done_cnt); end
        checks++;
        if (o_last_cyc != 3 || o_done_cyc != 4) begin
            errors++; $display("FAIL rd_timing: got last %0d done %0d expected 3 4", o_last_cyc, o_done_cyc);
        end
        repeat (2) @(negedge clk);
        checks++; if (done_data !== 64'hAA) begin errors++; $display("FAIL rd_done_hold: got %h expected aa", done_data); end
    endtask

    task automatic test_error_resp();
        rd_data.delete(); rd_resp.delete(); rd_last.delete();
        set_read(64'h1, 2'b00, 0);
        set_read(64'h2, 2'b10, 0);
        set_read(64'h4, 2'b11, 1);
        run_read(8'd2, 8'd3, 8'd3);
        checks++;
        if (o_resp !== 2'b10 || o_err !== 1'b0 || o_data !== 64'h7) begin
            errors++; $display("FAIL rd_slverr: got resp %b err %b data %h expected 10 0 7", o_resp, o_err, o_data);
        end
        run_write(8'd1, 64'h20, 8'd4, 2'b11, 8'd4, 0, 0);
        checks++;
        if (o_resp !== 2'b11 || o_err !== 1'b0) begin
            errors++; $display("FAIL wr_decerr: got resp %b err %b expected 11 0", o_resp, o_err);
        end
    endtask

    task automatic test_protocol_err();
        rd_data.delete(); rd_resp.delete(); rd_last.delete();
        set_read(64'h11, 2'b00, 0);
        set_read(64'h22, 2'b00, 1);
        run_read(8'd3, 8'd6, 8'd6);
        checks++;
        if (o_err !== 1'b1 || o_data !== 64'h33 || o_beats != 2) begin
            errors++; $display("FAIL rd_early_last: got err %b data %h beats %0d expected 1 33 2", o_err, o_data, o_beats);
        end
        checks++;
        if (o_done_cyc != o_last_cyc + 1 || o_last_cyc < 0) begin
            errors++; $display("FAIL rd_early_last_timing: got done %0d last %0d expected done = last+1", o_done_cyc, o_last_cyc);
        end
        run_write(8'd0, 64'h5, 8'd5, 2'b00, 8'd6, 0, 0);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL wr_bid_mismatch: got err %b expected 1", o_err); end
        rd_data.delete(); rd_resp.delete(); rd_last.delete();
        set_read(64'h1, 2'b00, 0);
        set_read(64'h2, 2'b00, 0);
        set_read(64'h4, 2'b00, 1);
        run_read(8'd0, 8'd2, 8'd2);
        checks++;
        if (o_err !== 1'b1 || o_data !== 64'h7 || o_timeout !== 1'b0) begin
            errors++; $display("FAIL rd_missing_last: got err %b data %h timeout %b expected 1 7 0", o_err, o_data, o_timeout);
        end
        rd_data.delete(); rd_resp.delete(); rd_last.delete();
        set_read(64'h8, 2'b00, 1);
        run_read(8'd0, 8'd2, 8'd3);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL rd_rid_mismatch: got err %b expected 1", o_err); end
    endtask

    task automatic test_backpressure();
        run_write(8'd3, 64'h100, 8'd7, 2'b00, 8'd7, 5, 1);
        checks++; if (o_aw_cnt != 6) begin errors++; $display("FAIL bp_aw_cycles: got %0d expected 6", o_aw_cnt); end
        checks++; if (o_unstable !== 1'b0) begin errors++; $display("FAIL bp_stable: got %b expected 0", o_unstable); end
        checks++; if (obs_w.size() != 4) begin errors++; $display("FAIL bp_beats: got %0d expected 4", obs_w.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_w[i] !== 64'h100 + 64'(i) || obs_last[i] !== (i == 3)) begin
                errors++; $display("FAIL bp_beat[%0d]: got data %h last %b expected data %h last %b",
                    i, obs_w[i], obs_last[i], 64'h100 + 64'(i), (i == 3));
            end
        end
        checks++; if (o_err !== 1'b0 || o_resp !== 2'b00) begin errors++; $display("FAIL bp_done: got err %b resp %b expected 0 00", o_err, o_resp); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int pulses;
        seen = 0; pulses = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 48'h2000; cmd_len = 8'd7; cmd_id = 8'd2; cmd_data = 64'h40;
        u_axi.aw_ready = 1; u_axi.w_ready = 1; u_axi.b_valid = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            cmd_valid = 0;
            if (done_valid) pulses++;
            if (u_axi.w_valid && u_axi.w_data === 64'h42) begin
                rst = 1; seen = 1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_mid_reach_beat2: got %b expected 1", seen); end
        @(negedge clk);
        checks++;
        if ({u_axi.aw_valid, u_axi.w_valid, u_axi.ar_valid, u_axi.b_ready, u_axi.r_ready} !== 5'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_outputs: got valids %b cmd_ready %b expected 00000 1",
                {u_axi.aw_valid, u_axi.w_valid, u_axi.ar_valid, u_axi.b_ready, u_axi.r_ready}, cmd_ready);
        end
        rst = 0;
        idle_inputs();
        repeat (5) begin
            if (done_valid) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", pulses); end
        rd_data.delete(); rd_resp.delete(); rd_last.delete();
        set_read(64'h3C, 2'b00, 1);
        run_read(8'd0, 8'd1, 8'd1);
        checks++;
        if (o_data !== 64'h3C || o_err !== 1'b0 || o_resp !== 2'b00 || o_done_cnt != 1) begin
            errors++; $display("FAIL rst_mid_read_after: got data %h err %b resp %b pulses %0d expected 3c 0 00 1",
                o_data, o_err, o_resp, o_done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_min_write();
        test_read_burst();
        test_error_resp();
        test_protocol_err();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
